// File: rtl/qrd_input_sequencer.sv
// qrd_input_sequencer: feeds (x, d) snapshots to the 3x3 QRD-RLS systolic array.
// A small FIFO buffers the incoming sample stream. A three-tap delay line then
// forms x[k], x[k-1], x[k-2]. A FIRE/GAP sequencer spaces the start pulses
// ISSUE_GAP cycles apart, so the array finishes one rotation sweep before the
// next snapshot arrives.
// Optional build macro QRD_SEQ_PREWINDOW_EN: after reset or clear, the first two
// LOADs only fill the tap line and do not raise start.
module qrd_input_sequencer #(
    parameter int DATA_LENGTH = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int ISSUE_GAP   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    input  logic                            enable,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_LENGTH-1:0]          s_x,
    input  logic [DATA_LENGTH-1:0]          s_d,
    output logic [DATA_LENGTH-1:0]          x0_out,
    output logic [DATA_LENGTH-1:0]          x1_out,
    output logic [DATA_LENGTH-1:0]          x2_out,
    output logic [DATA_LENGTH-1:0]          d_out,
    output logic                            start,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    // One issue period is IDLE + LOAD + FIRE + GAP_CYCLES cycles.
    localparam int GAP_CYCLES = ISSUE_GAP - 3;
    localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] GAP_LOAD = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, LOAD, FIRE, GAP} state_t;

    state_t                 state;
    logic [DATA_LENGTH-1:0] mem_x [FIFO_DEPTH];
    logic [DATA_LENGTH-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [LW-1:0]          level;
    logic [DATA_LENGTH-1:0] pop_x;
    logic [DATA_LENGTH-1:0] pop_d;
    logic [CW-1:0]          gap_cnt;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
`ifdef QRD_SEQ_PREWINDOW_EN
    logic [1:0]             warm_cnt;
`endif

    assign full       = (level == LW'(FIFO_DEPTH));
    assign empty      = (level == '0);
    assign s_ready    = !full;
    assign fifo_level = level;
    assign busy       = (state != IDLE);
    // s_ready depends only on the registered level, so a full FIFO refuses a
    // push even when the FSM pops in the same cycle.
    assign push       = s_valid && !full && !clear;
    assign pop        = (state == IDLE) && enable && !empty && !clear;

    // FIFO storage write.
    // NOTE: storage has no reset. Reads are gated by the level, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr] <= s_x;
            mem_d[wr_ptr] <= s_d;
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Issue sequencer: pop, shift the tap line, pulse start, then wait out the gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            x0_out   <= '0;
            x1_out   <= '0;
            x2_out   <= '0;
            d_out    <= '0;
            start    <= 1'b0;
            pop_x    <= '0;
            pop_d    <= '0;
            gap_cnt  <= '0;
`ifdef QRD_SEQ_PREWINDOW_EN
            warm_cnt <= '0;
`endif
        end else if (clear) begin
            state    <= IDLE;
            x0_out   <= '0;
            x1_out   <= '0;
            x2_out   <= '0;
            d_out    <= '0;
            start    <= 1'b0;
            gap_cnt  <= '0;
`ifdef QRD_SEQ_PREWINDOW_EN
            warm_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    start <= 1'b0;
                    if (pop) begin
                        pop_x <= mem_x[rd_ptr];
                        pop_d <= mem_d[rd_ptr];
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    x2_out <= x1_out;
                    x1_out <= x0_out;
                    x0_out <= pop_x;
                    d_out  <= pop_d;
`ifdef QRD_SEQ_PREWINDOW_EN
                    if (warm_cnt != 2'd2) begin
                        // Warm-up load: fill the taps without issuing.
                        warm_cnt <= warm_cnt + 2'd1;
                        gap_cnt  <= GAP_LOAD;
                        state    <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        start <= 1'b1;
                        state <= FIRE;
                    end
`else
                    start <= 1'b1;
                    state <= FIRE;
`endif
                end
                FIRE: begin
                    start   <= 1'b0;
                    gap_cnt <= GAP_LOAD;
                    state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
